// File: rtl/rtc_pkg.sv
// Shared field limits, alarm state encoding and hour helpers for the RTC.
package rtc_pkg;

  localparam int FIELD_W = 6;

  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] HR_MAX  = 6'd23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  // Increment a time field, wrapping to zero after its maximum.
  function automatic logic [FIELD_W-1:0] inc_wrap(input logic [FIELD_W-1:0] v,
                                                  input logic [FIELD_W-1:0] max_v);
    return (v == max_v) ? '0 : v + 6'd1;
  endfunction

  // 24 h hour to 12 h display hour: 0 -> 12, 13..23 -> 1..11.
  function automatic logic [FIELD_W-1:0] to_12h(input logic [FIELD_W-1:0] h);
    if (h == 6'd0)
      return 6'd12;
    else if (h > 6'd12)
      return h - 6'd12;
    else
      return h;
  endfunction

endpackage

// File: rtl/rtc_alarm_fsm.sv
// Alarm sequencer: ring with timeout, snooze countdown, off/disable abort.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | armed or disarmed, waiting for a time match
// RINGING | alarm output on, ring_cnt counts ticks down to auto-stop
// SNOOZE  | alarm output off, snooze_cnt counts ticks down to re-ring
module rtc_alarm_fsm
  import rtc_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic match,
  input  logic tick,
  input  logic snooze,
  input  logic off,
  input  logic en,
  output logic active
);

  localparam logic [7:0]  RING_LOAD   = 8'(RING_SEC);
  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);

  alarm_state_t state;
  logic [7:0]   ring_cnt;
  logic [11:0]  snooze_cnt;

  // State, countdown timers and the registered ringing flag; a count of 1
  // on a tick is the terminal count because that tick takes it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      active     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (match && en) begin
            state    <= RINGING;
            ring_cnt <= RING_LOAD;
            active   <= 1'b1;
          end
        end
        RINGING: begin
          if (off || !en) begin
            state  <= IDLE;
            active <= 1'b0;
          end else if (snooze) begin
            state      <= SNOOZE;
            snooze_cnt <= SNOOZE_LOAD;
            active     <= 1'b0;
          end else if (tick) begin
            ring_cnt <= ring_cnt - 8'd1;
            if (ring_cnt == 8'd1) begin
              state  <= IDLE;
              active <= 1'b0;
            end
          end
        end
        SNOOZE: begin
          if (off || !en) begin
            state  <= IDLE;
            active <= 1'b0;
          end else if (tick) begin
            snooze_cnt <= snooze_cnt - 12'd1;
            if (snooze_cnt == 12'd1) begin
              state    <= RINGING;
              ring_cnt <= RING_LOAD;
              active   <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rtc_core.sv
// Real-time clock: hh:mm:ss on a 1 Hz enable, 12/24 h display, day pulse,
// editable alarm and alarm sequencer.
module rtc_core
  import rtc_pkg::*;
#(
  parameter int SNOOZE_MIN  = 5,
  parameter int RING_SEC    = 60,
  parameter int ALARM_RST_H = 7,
  parameter int ALARM_RST_M = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_inc_hours,
  input  logic       i_inc_minutes,
  input  logic       i_alarm_set,
  input  logic       i_alarm_en,
  input  logic       i_snooze,
  input  logic       i_alarm_off,
  input  logic       i_mode_12h,
  output logic [5:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic       o_pm,
  output logic [5:0] o_alarm_hours,
  output logic [5:0] o_alarm_minutes,
  output logic       o_alarm_active,
  output logic       o_day_pulse
);

  logic [FIELD_W-1:0] sec_cnt, min_cnt, hr_cnt;
  logic [FIELD_W-1:0] alarm_hr, alarm_min;
  logic [FIELD_W-1:0] roll_min, roll_hr;
  logic time_edit, tick_eff, sec_wrap, min_wrap, hr_wrap, match;

  // A time-edit pulse owns the cycle, so a coincident tick is discarded.
  assign time_edit = !i_alarm_set && (i_inc_hours || i_inc_minutes);
  assign tick_eff  = i_tick && !time_edit;

  assign sec_wrap = (sec_cnt == SEC_MAX);
  assign min_wrap = (min_cnt == MIN_MAX);
  assign hr_wrap  = (hr_cnt == HR_MAX);

  assign roll_min = sec_wrap ? inc_wrap(min_cnt, MIN_MAX) : min_cnt;
  assign roll_hr  = (sec_wrap && min_wrap) ? inc_wrap(hr_cnt, HR_MAX) : hr_cnt;

  // Matches on the tick that lands on hh:mm:00 equal to the alarm.
  assign match = tick_eff && sec_wrap && (roll_min == alarm_min) && (roll_hr == alarm_hr);

  // Time-of-day counters and the registered day-rollover pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sec_cnt     <= '0;
      min_cnt     <= '0;
      hr_cnt      <= '0;
      o_day_pulse <= 1'b0;
    end else begin
      o_day_pulse <= tick_eff && sec_wrap && min_wrap && hr_wrap;
      if (time_edit) begin
        if (i_inc_minutes) begin
          min_cnt <= inc_wrap(min_cnt, MIN_MAX);
          sec_cnt <= '0;
        end
        if (i_inc_hours)
          hr_cnt <= inc_wrap(hr_cnt, HR_MAX);
      end else if (tick_eff) begin
        sec_cnt <= inc_wrap(sec_cnt, SEC_MAX);
        min_cnt <= roll_min;
        hr_cnt  <= roll_hr;
      end
    end
  end

  // Alarm time register, edited by the increment pulses while alarm_set is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alarm_hr  <= 6'(ALARM_RST_H);
      alarm_min <= 6'(ALARM_RST_M);
    end else if (i_alarm_set) begin
      if (i_inc_minutes)
        alarm_min <= inc_wrap(alarm_min, MIN_MAX);
      if (i_inc_hours)
        alarm_hr <= inc_wrap(alarm_hr, HR_MAX);
    end
  end

  rtc_alarm_fsm #(
    .SNOOZE_MIN (SNOOZE_MIN),
    .RING_SEC   (RING_SEC)
  ) u_alarm_fsm (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .match  (match),
    .tick   (tick_eff),
    .snooze (i_snooze),
    .off    (i_alarm_off),
    .en     (i_alarm_en),
    .active (o_alarm_active)
  );

  assign o_hours         = i_mode_12h ? to_12h(hr_cnt) : hr_cnt;
  assign o_alarm_hours   = i_mode_12h ? to_12h(alarm_hr) : alarm_hr;
  assign o_minutes       = min_cnt;
  assign o_seconds       = sec_cnt;
  assign o_alarm_minutes = alarm_min;
  assign o_pm            = (hr_cnt >= 6'd12);

endmodule

// File: doc/rtc_core.md
Name: rtc_core

Overview:
Parametrised successor to the hours/minutes counter. Runs on the system clock with a 1 Hz tick enable and counts seconds, minutes and hours. Adds a 12/24 h display mode, a day-rollover pulse, an editable alarm register, and an alarm state machine with snooze and ring timeout. Sits between the debounced button/switch inputs and the display/LED drivers.

Parameters:
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_SEC, 60, ring timeout in ticks before auto-stop (1..255)
ALARM_RST_H, 7, alarm hour after reset (0..23)
ALARM_RST_M, 0, alarm minute after reset (0..59)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset: asynchronous assert, active-low
i_tick  in  1  one-cycle 1 Hz enable, synchronous to i_clk
i_inc_hours  in  1  one-cycle debounced pulse
i_inc_minutes  in  1  one-cycle debounced pulse
i_alarm_set  in  1  level; 1 = increment pulses edit the alarm instead of the time
i_alarm_en  in  1  level; alarm armed
i_snooze  in  1  one-cycle pulse
i_alarm_off  in  1  one-cycle pulse
i_mode_12h  in  1  level; 1 = 12 h display
o_hours  out  6  display hour (0..23, or 1..12 in 12 h mode)
o_minutes  out  6  0..59
o_seconds  out  6  0..59
o_pm  out  1  1 when internal hour >= 12 (valid in both modes)
o_alarm_hours  out  6  alarm hour in the current display mode
o_alarm_minutes  out  6  alarm minute
o_alarm_active  out  1  1 while ringing
o_day_pulse  out  1  one-cycle pulse on 23:59:59 -> 00:00:00

Behaviour:
- Reset (i_rst_n=0, asynchronous): time 00:00:00; alarm ALARM_RST_H:ALARM_RST_M; FSM IDLE; o_alarm_active=0; o_day_pulse=0. Display in 12 h mode after reset: o_hours=12, o_pm=0.
- Time is stored internally in 24 h form only. Display conversion is combinational from registers:
  - internal 0 -> 12 (AM); 1..11 unchanged; 12 -> 12 (PM); 13..23 -> h-12.
  - Outputs reflect a register update on the cycle after the triggering edge. No further latency.
- Tick (i_tick=1 with no time-edit pulse this cycle):
  - seconds+1.
  - 59 wraps to 0 and carries into minutes; minutes 59 wraps to 0 and carries into hours; hours 23 wraps to 0.
  - o_day_pulse is registered and high for exactly the one cycle following the 23:59:59 wrap.
- Time edit (i_alarm_set=0):
  - i_inc_minutes: minutes+1 mod 60, seconds cleared to 0, no carry into hours.
  - i_inc_hours: hours+1 mod 24.
  - Both pulses in the same cycle: both applied independently, seconds cleared.
  - An edit pulse in the same cycle as i_tick wins; that tick is dropped (no seconds advance, no carry, no alarm match, no day pulse).
- Alarm edit (i_alarm_set=1):
  - Same wrap rules applied to the alarm registers; no carry.
  - Time keeps running on ticks.
  - Allowed in any FSM state; does not change the FSM state.
- Alarm FSM, three states IDLE, RINGING, SNOOZE. ring_cnt is 8 bits; snooze_cnt is 12 bits, counting ticks.
  - Match: a tick that produces seconds==0 with hh:mm equal to the alarm.
  - IDLE -> RINGING: on match while i_alarm_en=1; load ring_cnt=RING_SEC.
  - RINGING:
    - o_alarm_active=1; ring_cnt decrements on each tick.
    - i_alarm_off=1 or i_alarm_en=0 -> IDLE.
    - else i_snooze -> SNOOZE, load snooze_cnt=SNOOZE_MIN*60.
    - else ring_cnt reaching 0 -> IDLE.
  - SNOOZE:
    - snooze_cnt decrements on each tick.
    - i_alarm_off or i_alarm_en=0 -> IDLE.
    - snooze_cnt reaching 0 -> RINGING, reload ring_cnt.
    - i_snooze is ignored.
  - Priority within a cycle: off/disable > snooze > counter expiry.
  - A match while in RINGING or SNOOZE is ignored.
  - o_alarm_active is registered: 1 exactly when the state is RINGING.
- Mode switch (i_mode_12h toggled) affects display only; no register changes, no FSM effect.
- Reset mid-ring or mid-snooze returns the FSM to IDLE immediately; o_alarm_active drops asynchronously.

Decomposition:
- Package rtc_pkg holds:
  - field limits SEC_MAX=59, MIN_MAX=59, HR_MAX=23
  - the 6-bit field width
  - the FSM state encoding (IDLE=2'd0, RINGING=2'd1, SNOOZE=2'd2)
  - the 24-to-12 h conversion function
- Sub-module rtc_alarm_fsm:
  - inputs: match, tick, snooze, off, en
  - contains the state register and the ring/snooze counters
  - output: active

Test Plan:
- Reset, then 3661 ticks -> time 01:01:01; 12 h mode shows o_hours=1, o_pm=0; after reset, 12 h shows o_hours=12, o_pm=0.
- Preload 23:59:58, give 2 ticks -> 00:00:00; o_day_pulse high for exactly 1 cycle after the second tick.
- Time 10:59:30, pulse i_inc_minutes -> 10:00:00 (no hour carry); pulse i_inc_hours at 23:xx -> 00:xx; edit pulse coincident with tick -> seconds unchanged.
- Alarm 07:00, enabled, run from 06:59:58 -> o_alarm_active rises after the tick reaching 07:00:00; with no input it falls after RING_SEC=60 ticks.
- While ringing, pulse i_snooze -> active=0; after 300 ticks active=1 again; i_snooze and i_alarm_off in the same cycle -> IDLE, active=0, no re-ring.
- While ringing, drive i_rst_n low mid-cycle -> o_alarm_active=0 and time 00:00:00 without waiting for a clock edge; alarm back to 07:00.
